// File: rtl/booth_mul_pkg.sv
// Shared definitions for the Booth multiplier scheduler: FSM states and the
// fixed operand width of the multiplier tree.
package booth_mul_pkg;

    localparam int unsigned BOOTH_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

endpackage

// File: rtl/Booth.sv
// Combinational signed x signed radix-4 Booth multiplier producing the full
// 2*WIDTH-bit two's-complement product.
module Booth #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned NPP = WIDTH / 2;

    logic [WIDTH:0]     yb;
    logic [2*WIDTH-1:0] xe;
    logic [2*WIDTH-1:0] x2;
    logic [2*WIDTH-1:0] acc [NPP+1];

    assign yb     = {y, 1'b0};
    assign xe     = {{WIDTH{x[WIDTH-1]}}, x};
    assign x2     = xe << 1;
    assign acc[0] = '0;

    // Each overlapping triplet of y selects a digit in {-2,-1,0,+1,+2}.
    for (genvar j = 0; j < NPP; j++) begin : g_pp
        logic [2*WIDTH-1:0] pp;
        always_comb begin
            case (yb[2*j +: 3])
                3'b001, 3'b010: pp = xe;
                3'b011:         pp = x2;
                3'b100:         pp = -x2;
                3'b101, 3'b110: pp = -xe;
                default:        pp = '0;
            endcase
        end
        assign acc[j+1] = acc[j] + (pp << (2*j));
    end

    assign p = acc[NPP];

endmodule

// File: rtl/booth_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after prio,
// wrapping modulo NREQ; grant is suppressed when en is low.
module booth_rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  prio,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(prio) + k) % NREQ);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one Booth multiplier between NREQ requesters.
// Optional busy_cycles counter enabled by BOOTH_MUL_SCHED_BUSY_CNT_EN.
module booth_mul_sched
    import booth_mul_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = BOOTH_WIDTH,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*WIDTH-1:0]    rsp_p,
    output logic [IDW-1:0]        rsp_id
`ifdef BOOTH_MUL_SCHED_BUSY_CNT_EN
    ,
    output logic [31:0]           busy_cycles
`endif
);

    if (WIDTH != BOOTH_WIDTH) begin : g_width_chk
        $error("booth_mul_sched: WIDTH must be 32");
    end

    state_t             state, state_nx;
    logic [IDW-1:0]     prio, gnt_idx, op_id;
    logic [NREQ-1:0]    gnt;
    logic               arb_en, hs;
    logic [WIDTH-1:0]   op_x, op_y;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   xs [NREQ];
    logic [WIDTH-1:0]   ys [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign xs[i] = req_x[i*WIDTH +: WIDTH];
        assign ys[i] = req_y[i*WIDTH +: WIDTH];
    end

    // Grant may be issued while a finished product is being taken, giving back-to-back ops.
    assign arb_en = (state == IDLE) || ((state == DONE) && rsp_ready);
    assign hs     = |(req_valid & req_ready);

    booth_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .prio    (prio),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    Booth #(
        .WIDTH (WIDTH)
    ) u_booth (
        .x (op_x),
        .y (op_y),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (hs) state_nx = MUL;
            MUL:     state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = hs ? MUL : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state == DONE);
        req_ready = rst ? '0 : gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_x   <= '0;
            op_y   <= '0;
            op_id  <= '0;
            prio   <= '0;
            rsp_p  <= '0;
            rsp_id <= '0;
        end else begin
            if (hs) begin
                op_x  <= xs[gnt_idx];
                op_y  <= ys[gnt_idx];
                op_id <= gnt_idx;
                prio  <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (state == MUL) begin
                rsp_p  <= prod;
                rsp_id <= op_id;
            end
        end
    end

`ifdef BOOTH_MUL_SCHED_BUSY_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cycles <= '0;
        end else if (state != IDLE) begin
            busy_cycles <= busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_booth_mul_sched.sv
// Self-checking bench for booth_mul_sched: behavioural round-robin/latency model
// plus directed literal checks, then randomized traffic with stalls and resets.
module tb_booth_mul_sched;

    localparam int N = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_x;
    logic [N*32-1:0] req_y;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [63:0]     rsp_p;
    logic [1:0]      rsp_id;
`ifdef BOOTH_MUL_SCHED_BUSY_CNT_EN
    logic [31:0]     busy_cycles;
`endif

    booth_mul_sched #(
        .NREQ  (N),
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id)
`ifdef BOOTH_MUL_SCHED_BUSY_CNT_EN
        ,
        .busy_cycles (busy_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        longint la, lb;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        return 64'(la * lb);
    endfunction

    function automatic logic [N-1:0] rr(input logic [N-1:0] v, input int p);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) begin
                r[(p + k) % N] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom % 8)
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Behavioural model: an accepted op becomes visible two cycles later and
    // stays until consumed; a new grant is possible only when nothing is held
    // or the held product is being taken this cycle.
    int          cyc = 0;
    int          mprio = 0;
    bit          inflight = 0;
    bit          have_res = 0;
    int          hs_cyc = 0;
    int          exp_id = 0;
    logic [63:0] exp_p = '0;
    int unsigned mbusy = 0;
    logic [N-1:0] last_gnt = '0;

    always @(negedge clk) begin
        logic [N-1:0] eg;
        bit           vis;
        cyc++;
        if (rst) begin
            chk("ready_in_reset", 64'(req_ready), 64'd0);
            inflight = 0;
            have_res = 0;
            mprio    = 0;
            mbusy    = 0;
            last_gnt = '0;
        end else begin
            vis = inflight && (cyc >= hs_cyc + 2);
            eg  = (!inflight || (vis && rsp_ready)) ? rr(req_valid, mprio) : '0;
            chk("req_ready", 64'(req_ready), 64'(eg));
            chk("rsp_valid", 64'(rsp_valid), 64'(vis));
            if (vis) begin
                chk("rsp_p", rsp_p, exp_p);
                chk("rsp_id", 64'(rsp_id), 64'(exp_id));
                have_res = 1;
            end else if (!have_res) begin
                chk("rsp_p_zero", rsp_p, 64'd0);
            end
`ifdef BOOTH_MUL_SCHED_BUSY_CNT_EN
            chk("busy_cycles", 64'(busy_cycles), 64'(mbusy));
`endif
            if (inflight) mbusy++;
            if (vis && rsp_ready) inflight = 0;
            if (eg != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (eg[i]) begin
                        exp_id = i;
                        exp_p  = smul(req_x[i*32 +: 32], req_y[i*32 +: 32]);
                        mprio  = (i + 1) % N;
                    end
                end
                inflight = 1;
                hs_cyc   = cyc;
            end
            last_gnt = eg;
        end
    end

    // Advance one cycle; requesters granted at this edge drop their request.
    task automatic cyc_();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~last_gnt;
    endtask

    task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y);
        req_x[i*32 +: 32] = x;
        req_y[i*32 +: 32] = y;
        req_valid[i]      = 1'b1;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        repeat (14) cyc_();
    endtask

    task automatic run_one(input int i, input logic [31:0] x, input logic [31:0] y,
                           input logic [63:0] ep);
        int n;
        set_req(i, x, y);
        @(negedge clk);
        chk("one_gnt", 64'(req_ready), 64'(1) << i);
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc_();
            @(negedge clk);
            n = k;
            if (rsp_valid) break;
        end
        chk("one_latency", 64'(n), 64'd2);
        chk("one_p_literal", rsp_p, ep);
        chk("one_id_literal", 64'(rsp_id), 64'(i));
        cyc_();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
        repeat (3) cyc_();
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_ready", 64'(req_ready), 64'd0);
            chk("idle_valid", 64'(rsp_valid), 64'd0);
            chk("idle_p", rsp_p, 64'd0);
            cyc_();
        end

        run_one(2, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        run_one(0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_one(0, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);

        // All requesters continuously valid from prio 0
        rst = 1'b1;
        cyc_();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("rr_gnt", 64'(req_ready), 64'(1) << ((k / 2) % N));
            end else begin
                chk("rr_gnt_mul", 64'(req_ready), 64'd0);
            end
            chk("rr_valid", 64'(rsp_valid), 64'((k >= 2) && (k % 2 == 0)));
            if (k >= 2 && k % 2 == 0) chk("rr_id", 64'(rsp_id), 64'(((k / 2) - 1) % N));
            cyc_();
            for (int i = 0; i < N; i++) if (!req_valid[i]) set_req(i, $urandom, $urandom);
        end
        drain();

        // Consumer stall in DONE
        rsp_ready = 1'b0;
        set_req(0, 32'd1000, 32'hFFFF_FFFB);
        @(negedge clk);
        chk("stall_gnt", 64'(req_ready), 64'd1);
        for (int k = 0; k < 10; k++) begin
            cyc_();
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("stall_valid", 64'(rsp_valid), 64'd1);
        cyc_();
        set_req(1, 32'd3, 32'd4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_p", rsp_p, 64'hFFFF_FFFF_FFFF_EC78);
            chk("stall_id", 64'(rsp_id), 64'd0);
            chk("stall_ready", 64'(req_ready), 64'd0);
            cyc_();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_gnt", 64'(req_ready), 64'd2);
        drain();

        // Reset while an operation is in MUL
        set_req(0, $urandom, $urandom);
        @(negedge clk);
        chk("rstmul_gnt", 64'(req_ready), 64'd1);
        cyc_();
        rst = 1'b1;
        cyc_();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rstmul_novalid", 64'(rsp_valid), 64'd0);
`ifdef BOOTH_MUL_SCHED_BUSY_CNT_EN
            chk("rstmul_busy0", 64'(busy_cycles), 64'd0);
`endif
            cyc_();
        end
        set_req(1, $urandom, $urandom);
        set_req(3, $urandom, $urandom);
        @(negedge clk);
        chk("rstmul_prio", 64'(req_ready), 64'd2);
        drain();

        rst = 1'b1;
        cyc_();
        rst = 1'b0;
        run_one(2, 32'd5, 32'd6, 64'd30);
`ifdef BOOTH_MUL_SCHED_BUSY_CNT_EN
        @(negedge clk);
        chk("busy_one_op", 64'(busy_cycles), 64'd2);
`endif

        // Randomized traffic with back-pressure and occasional resets
        for (int c = 0; c < 3000; c++) begin
            cyc_();
            rsp_ready = ($urandom % 10) < 7;
            rst       = ($urandom % 400) == 0;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 4) == 0) set_req(i, rnd32(), rnd32());
            end
        end
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
